// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if -- signal bundle between the sequencer and its environment.
//   instr_*      : instruction handshake (valid/ready) and fields
//   alu_a/b/sel  : registered operands and select toward an external ALU
//   alu_result,
//   alu_carry,
//   alu_zero     : combinational ALU answer coming back
//   wb_*         : one-cycle writeback report
//   flag_c/z,
//   op_count     : status from completed ALU operations
//   dbg_addr/data: combinational register-file peek
// slave  = the sequencer side, master = the driver/ALU side.
interface alu_sequencer_if;
  logic       instr_valid;
  logic       instr_ready;
  logic       instr_load;
  logic [2:0] instr_op;
  logic [1:0] instr_rd;
  logic [1:0] instr_ra;
  logic [1:0] instr_rb;
  logic [3:0] instr_imm;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       alu_zero;
  logic       wb_valid;
  logic [1:0] wb_rd;
  logic [3:0] wb_data;
  logic       flag_c;
  logic       flag_z;
  logic [7:0] op_count;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;

  modport slave (
    input  instr_valid, instr_load, instr_op, instr_rd, instr_ra, instr_rb,
           instr_imm, alu_result, alu_carry, alu_zero, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_sel, wb_valid, wb_rd, wb_data,
           flag_c, flag_z, op_count, dbg_data
  );

  modport master (
    output instr_valid, instr_load, instr_op, instr_rd, instr_ra, instr_rb,
           instr_imm, alu_result, alu_carry, alu_zero, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_sel, wb_valid, wb_rd, wb_data,
           flag_c, flag_z, op_count, dbg_data
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer -- two-state sequencer around a 4x4-bit register file that
// executes load-immediate instructions in one cycle and drives an external
// combinational ALU for register-register operations (accept + one EXEC cycle).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_sequencer_if.slave (instruction handshake, ALU operands and
//           result, writeback report, flags, op counter, debug read)
module alu_sequencer (
  input  logic              clk,
  input  logic              rst_n,
  alu_sequencer_if.slave    bus
);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_ready;
  logic            w_accept;

  logic [3:0][3:0] r_rf;
  logic [3:0]      r_alu_a;
  logic [3:0]      r_alu_b;
  logic [2:0]      r_alu_sel;
  logic [1:0]      r_rd;
  logic            r_wb_valid;
  logic [1:0]      r_wb_rd;
  logic [3:0]      r_wb_data;
  logic            r_flag_c;
  logic            r_flag_z;
  logic [7:0]      r_op_count;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and handshake. Ready is gated by rst_n so it reads 0 while
  // reset is held and rises as soon as reset is released.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready  = rst_n;
        w_accept = bus.instr_valid & w_ready;
        if (w_accept && !bus.instr_load) w_state_nxt = EXEC;
      end
      EXEC: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath. Accepts only happen in IDLE and writeback of an ALU op only in
  // EXEC, so the two register-file write ports never collide. Operands are
  // read from r_rf before the edge, which gives load-then-use and
  // rd==ra forwarding-free correctness for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf       <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_sel  <= '0;
      r_rd       <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_flag_c   <= 1'b0;
      r_flag_z   <= 1'b0;
      r_op_count <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      if (w_accept) begin
        if (bus.instr_load) begin
          r_rf[bus.instr_rd] <= bus.instr_imm;
          r_wb_rd            <= bus.instr_rd;
          r_wb_data          <= bus.instr_imm;
          r_wb_valid         <= 1'b1;
        end else begin
          r_alu_a   <= r_rf[bus.instr_ra];
          r_alu_b   <= r_rf[bus.instr_rb];
          r_alu_sel <= bus.instr_op;
          r_rd      <= bus.instr_rd;
        end
      end
      if (r_state == EXEC) begin
        r_rf[r_rd] <= bus.alu_result;
        r_wb_rd    <= r_rd;
        r_wb_data  <= bus.alu_result;
        r_wb_valid <= 1'b1;
        r_flag_c   <= bus.alu_carry;
        r_flag_z   <= bus.alu_zero;
        r_op_count <= r_op_count + 8'd1;
      end
    end
  end

  assign bus.instr_ready = w_ready;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_sel     = r_alu_sel;
  assign bus.wb_valid    = r_wb_valid;
  assign bus.wb_rd       = r_wb_rd;
  assign bus.wb_data     = r_wb_data;
  assign bus.flag_c      = r_flag_c;
  assign bus.flag_z      = r_flag_z;
  assign bus.op_count    = r_op_count;
  assign bus.dbg_data    = r_rf[bus.dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer -- directed bench for alu_sequencer with a behavioural
// 4-bit ALU on the alu_* ports (000 add, carry = carry-out; 001 sub,
// carry = borrow; 010 and; 011 or; 100 xor; others pass A).
module tb_alu_sequencer;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_sequencer_if bus();

  alu_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] alu_t;
  always_comb begin
    alu_t = '0;
    case (bus.alu_sel)
      3'b000: alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'b001: alu_t = {(bus.alu_a < bus.alu_b), bus.alu_a - bus.alu_b};
      3'b010: alu_t = {1'b0, bus.alu_a & bus.alu_b};
      3'b011: alu_t = {1'b0, bus.alu_a | bus.alu_b};
      3'b100: alu_t = {1'b0, bus.alu_a ^ bus.alu_b};
      default: alu_t = {1'b0, bus.alu_a};
    endcase
    bus.alu_result = alu_t[3:0];
    bus.alu_carry  = alu_t[4];
    bus.alu_zero   = (alu_t[3:0] == 4'd0);
  end

  task automatic drive(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] ra, input logic [1:0] rb, input logic [3:0] imm);
    bus.instr_valid = 1'b1;
    bus.instr_load  = ld;
    bus.instr_op    = op;
    bus.instr_rd    = rd;
    bus.instr_ra    = ra;
    bus.instr_rb    = rb;
    bus.instr_imm   = imm;
  endtask

  task automatic idle_bus();
    bus.instr_valid = 1'b0;
    bus.instr_load  = 1'b0;
    bus.instr_op    = 3'd7;
    bus.instr_rd    = 2'd3;
    bus.instr_ra    = 2'd3;
    bus.instr_rb    = 2'd3;
    bus.instr_imm   = 4'hF;
  endtask

  // One load: accept edge, wb visible right after.
  task automatic do_load(input logic [1:0] rd, input logic [3:0] imm);
    drive(1'b1, 3'd0, rd, 2'd0, 2'd0, imm);
    @(posedge clk); #1;
    idle_bus();
  endtask

  // One ALU op: accept edge then EXEC edge; returns just after writeback.
  task automatic do_alu(input logic [2:0] op, input logic [1:0] rd,
                        input logic [1:0] ra, input logic [1:0] rb);
    drive(1'b0, op, rd, ra, rb, 4'd0);
    @(posedge clk); #1;
    idle_bus();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_bus();
    bus.dbg_addr = 2'd0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_low got %0b want 0", bus.instr_ready); end
    checks++; if (bus.wb_valid !== 1'b0 || bus.op_count !== 8'd0) begin errors++; $display("FAIL rst_wb_cnt got %0b/%0d want 0/0", bus.wb_valid, bus.op_count); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_high got %0b want 1", bus.instr_ready); end
    checks++; if (bus.flag_c !== 1'b0 || bus.flag_z !== 1'b0) begin errors++; $display("FAIL rst_flags got c%0b z%0b want 0 0", bus.flag_c, bus.flag_z); end
    for (int i = 0; i < 4; i++) begin
      bus.dbg_addr = 2'(i);
      #1;
      checks++; if (bus.dbg_data !== 4'd0) begin errors++; $display("FAIL rst_rf%0d got %0h want 0", i, bus.dbg_data); end
    end
  endtask

  task automatic test_add();
    drive(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd9);
    @(posedge clk); #1;
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 2'd1 || bus.wb_data !== 4'd9) begin errors++; $display("FAIL load_r1 got v%0b rd%0d d%0h want v1 rd1 d9", bus.wb_valid, bus.wb_rd, bus.wb_data); end
    checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL load_ready got %0b want 1", bus.instr_ready); end
    drive(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 4'd8);
    @(posedge clk); #1;
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 2'd2 || bus.wb_data !== 4'd8) begin errors++; $display("FAIL load_r2 got v%0b rd%0d d%0h want v1 rd2 d8", bus.wb_valid, bus.wb_rd, bus.wb_data); end
    drive(1'b0, 3'b000, 2'd3, 2'd1, 2'd2, 4'd0);
    @(posedge clk); #1;
    idle_bus();
    checks++; if (bus.alu_a !== 4'd9 || bus.alu_b !== 4'd8 || bus.alu_sel !== 3'd0) begin errors++; $display("FAIL add_operands got a%0h b%0h s%0d want a9 b8 s0", bus.alu_a, bus.alu_b, bus.alu_sel); end
    checks++; if (bus.instr_ready !== 1'b0 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL add_exec got rdy%0b wb%0b want 0 0", bus.instr_ready, bus.wb_valid); end
    @(posedge clk); #1;
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 2'd3 || bus.wb_data !== 4'd1) begin errors++; $display("FAIL add_wb got v%0b rd%0d d%0h want v1 rd3 d1", bus.wb_valid, bus.wb_rd, bus.wb_data); end
    checks++; if (bus.flag_c !== 1'b1 || bus.flag_z !== 1'b0 || bus.op_count !== 8'd1) begin errors++; $display("FAIL add_flags got c%0b z%0b n%0d want c1 z0 n1", bus.flag_c, bus.flag_z, bus.op_count); end
    @(posedge clk); #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL add_wb_pulse got %0b want 0", bus.wb_valid); end
    checks++; if (bus.alu_a !== 4'd9 || bus.alu_b !== 4'd8) begin errors++; $display("FAIL add_hold got a%0h b%0h want 9 8", bus.alu_a, bus.alu_b); end
    bus.dbg_addr = 2'd3; #1;
    checks++; if (bus.dbg_data !== 4'd1) begin errors++; $display("FAIL add_rf3 got %0h want 1", bus.dbg_data); end
  endtask

  task automatic test_sub();
    do_load(2'd0, 4'd5);
    do_alu(3'b001, 2'd0, 2'd1, 2'd1);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 2'd0 || bus.wb_data !== 4'd0) begin errors++; $display("FAIL sub_wb got v%0b rd%0d d%0h want v1 rd0 d0", bus.wb_valid, bus.wb_rd, bus.wb_data); end
    checks++; if (bus.flag_z !== 1'b1 || bus.flag_c !== 1'b0 || bus.op_count !== 8'd2) begin errors++; $display("FAIL sub_flags got c%0b z%0b n%0d want c0 z1 n2", bus.flag_c, bus.flag_z, bus.op_count); end
    bus.dbg_addr = 2'd0; #1;
    checks++; if (bus.dbg_data !== 4'd0) begin errors++; $display("FAIL sub_rf0 got %0h want 0", bus.dbg_data); end
  endtask

  // r1 = r1 + r1 twice with valid held: r1 9 -> 2 (c1) -> 4 (c0).
  task automatic test_back_to_back();
    logic [3:0] rdy;
    logic [3:0] wbv;
    logic [3:0] d1, d2;
    @(posedge clk); #1;
    drive(1'b0, 3'b000, 2'd1, 2'd1, 2'd1, 4'd0);
    rdy[0] = bus.instr_ready;
    @(posedge clk); #1; rdy[1] = bus.instr_ready; wbv[0] = bus.wb_valid;
    @(posedge clk); #1; rdy[2] = bus.instr_ready; wbv[1] = bus.wb_valid; d1 = bus.wb_data;
    @(posedge clk); #1; rdy[3] = bus.instr_ready; wbv[2] = bus.wb_valid;
    idle_bus();
    @(posedge clk); #1; wbv[3] = bus.wb_valid; d2 = bus.wb_data;
    checks++; if (rdy !== 4'b0101) begin errors++; $display("FAIL b2b_ready got %b want 0101 (lsb first sample)", rdy); end
    checks++; if (wbv !== 4'b1010) begin errors++; $display("FAIL b2b_wb got %b want 1010 (lsb first sample)", wbv); end
    checks++; if (d1 !== 4'd2 || d2 !== 4'd4) begin errors++; $display("FAIL b2b_data got %0h %0h want 2 4", d1, d2); end
    checks++; if (bus.op_count !== 8'd4 || bus.flag_c !== 1'b0 || bus.flag_z !== 1'b0) begin errors++; $display("FAIL b2b_status got n%0d c%0b z%0b want n4 c0 z0", bus.op_count, bus.flag_c, bus.flag_z); end
    @(posedge clk); #1;
    checks++; if (bus.wb_valid !== 1'b0 || bus.instr_ready !== 1'b1) begin errors++; $display("FAIL b2b_tail got wb%0b rdy%0b want 0 1", bus.wb_valid, bus.instr_ready); end
  endtask

  task automatic test_reset_mid_exec();
    do_load(2'd1, 4'd3);
    do_load(2'd2, 4'd4);
    drive(1'b0, 3'b000, 2'd3, 2'd1, 2'd2, 4'd0);
    @(posedge clk); #1;
    idle_bus();
    rst_n = 1'b0; #1;
    checks++; if (bus.instr_ready !== 1'b0 || bus.alu_a !== 4'd0 || bus.alu_b !== 4'd0) begin errors++; $display("FAIL mid_rst_hold got rdy%0b a%0h b%0h want 0 0 0", bus.instr_ready, bus.alu_a, bus.alu_b); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_wb got %0b want 0", bus.wb_valid); end
    checks++; if (bus.op_count !== 8'd0 || bus.flag_c !== 1'b0 || bus.flag_z !== 1'b0) begin errors++; $display("FAIL mid_rst_status got n%0d c%0b z%0b want 0 0 0", bus.op_count, bus.flag_c, bus.flag_z); end
    for (int i = 0; i < 4; i++) begin
      bus.dbg_addr = 2'(i); #1;
      checks++; if (bus.dbg_data !== 4'd0) begin errors++; $display("FAIL mid_rst_rf%0d got %0h want 0", i, bus.dbg_data); end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 128; i++) do_alu(3'b000, 2'd0, 2'd1, 2'd2);
    checks++; if (bus.op_count !== 8'd128) begin errors++; $display("FAIL wrap_128 got %0d want 128", bus.op_count); end
    do_load(2'd1, 4'd7);
    checks++; if (bus.op_count !== 8'd128 || bus.wb_valid !== 1'b1) begin errors++; $display("FAIL wrap_load1 got n%0d wb%0b want 128 1", bus.op_count, bus.wb_valid); end
    for (int i = 0; i < 127; i++) do_alu(3'b100, 2'd2, 2'd1, 2'd2);
    checks++; if (bus.op_count !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d want 255", bus.op_count); end
    do_load(2'd3, 4'd2);
    checks++; if (bus.op_count !== 8'd255) begin errors++; $display("FAIL wrap_load2 got %0d want 255", bus.op_count); end
    do_alu(3'b000, 2'd0, 2'd3, 2'd3);
    checks++; if (bus.op_count !== 8'd0 || bus.wb_data !== 4'd4) begin errors++; $display("FAIL wrap_0 got n%0d d%0h want 0 4", bus.op_count, bus.wb_data); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_mid_exec();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; there are no parameters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 instr_valid  input  1  instruction offered this cycle.
REQ-005 instr_ready  output  1  block can accept an instruction this cycle.
REQ-006 instr_load  input  1  1 = load immediate, 0 = ALU operation.
REQ-007 instr_op  input  3  ALU select code, passed unchanged to alu_sel.
REQ-008 instr_rd, instr_ra, instr_rb  input  2 each  destination, source-A and source-B register indices.
REQ-009 instr_imm  input  4  immediate value for a load.
REQ-010 alu_a, alu_b  output  4 each  registered ALU operands.
REQ-011 alu_sel  output  3  registered ALU select.
REQ-012 alu_result  input  4  ALU result, combinational from alu_a/alu_b/alu_sel.
REQ-013 alu_carry, alu_zero  input  1 each  ALU flags, combinational from alu_a/alu_b/alu_sel.
REQ-014 wb_valid  output  1  one-cycle pulse: a register write completed.
REQ-015 wb_rd  output  2  index of the register written.
REQ-016 wb_data  output  4  value written.
REQ-017 flag_c, flag_z  output  1 each  carry and zero flags held from the last completed ALU operation.
REQ-018 op_count  output  8  count of completed ALU operations.
REQ-019 dbg_addr  input  2  debug read index.
REQ-020 dbg_data  output  4  combinational read of the register selected by dbg_addr.

Function
REQ-021 Register file: 4 entries x 4 bits (r0-r3); all are general purpose.
REQ-022 State machine states: IDLE and EXEC.
- instr_ready = 1 in IDLE, 0 in EXEC.
- Handshake: an instruction is accepted on a rising edge where instr_valid & instr_ready.
REQ-023 Load accepted in IDLE, at that edge:
- rf[rd] <= imm; wb_rd <= rd; wb_data <= imm; wb_valid <= 1.
- Remain in IDLE; flags, op_count and alu_* are unchanged.
REQ-024 ALU operation accepted in IDLE, at that edge:
- alu_a <= rf[ra]; alu_b <= rf[rb]; alu_sel <= op.
- Source registers are read with their values from before that edge.
- Latch rd internally; go to EXEC.
REQ-025 EXEC lasts exactly one cycle; at its closing edge:
- rf[rd] <= alu_result; wb_rd <= rd; wb_data <= alu_result; wb_valid <= 1.
- flag_c <= alu_carry; flag_z <= alu_zero; op_count <= op_count + 1.
- Go to IDLE.
REQ-026 Latency and throughput:
- ALU op accepted at edge N: writeback visible in the cycle after edge N+1; next accept no earlier than edge N+2.
- Loads: one per cycle.
REQ-027 wb_valid SHALL be high for exactly one cycle per completed instruction and low otherwise.
REQ-028 alu_a, alu_b and alu_sel SHALL hold their values until the next accepted ALU operation.
REQ-029 instr_valid held high while instr_ready = 0 SHALL cause no action; the instruction is accepted at the next IDLE edge.
REQ-030 Operand hazards are avoided by construction:
- An ALU op may read its own destination, e.g. r1 = r1 + r1.
- An instruction following a load reads the loaded value.
REQ-031 op_count SHALL wrap from 255 to 0; loads do not increment it.
REQ-032 Instruction fields are ignored unless an instruction is accepted.

Reset
REQ-033 While rst_n = 0, regardless of clk, the block SHALL hold:
- state IDLE; all rf entries 0; alu_a, alu_b, alu_sel 0.
- wb_valid, wb_rd, wb_data 0; flag_c, flag_z 0; op_count 0.
- instr_ready 0.
REQ-034 instr_ready SHALL be 1 from the first cycle after rst_n deasserts.
REQ-035 Reset asserted during EXEC SHALL abort the operation with no writeback and no flag or counter update.

Verification (bench connects the 4-bit ALU to the alu_* ports)
REQ-036 Reset release -> dbg_data = 0 for all 4 indices, instr_ready = 1, flag_c = flag_z = 0, op_count = 0.
REQ-037 LOAD r1=9, LOAD r2=8, then ADD (op 000) r3=r1+r2:
- alu_a = 9, alu_b = 8.
- wb pulse with rd 3 and data 1.
- flag_c = 1, flag_z = 0, op_count = 1.
REQ-038 SUB (op 001) r0 = r1 - r1, with r1 = 9 -> wb_data = 0, flag_z = 1, flag_c = 0, dbg_data[r0] = 0.
REQ-039 Back-to-back ALU ops with instr_valid held high:
- instr_ready toggles 1,0,1,0.
- Accepts are spaced 2 cycles apart; each op has exactly one wb_valid pulse.
REQ-040 rst_n pulsed low mid-EXEC of an ADD:
- No wb_valid pulse.
- All registers and flags read 0; op_count = 0.
REQ-041 256 completed ALU ops -> op_count returns to 0; interleaved loads do not change the count.
